turnstile_arbiter: RTL and testbench

//  Shares one physical turnstile between an entry requester and an exit requester.

---
 rtl/turnstile_arbiter.sv | 177 +++++++++++++++++
 tb/tb_turnstile_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/turnstile_arbiter.sv
// turnstile_arbiter: shares one turnstile between an entry and an exit requester.
// Grants one direction at a time, confirms each passage with the rotation sensor
// or aborts the grant on timeout, and keeps the room occupancy within a capacity.
module turnstile_arbiter #(
    parameter int TIMEOUT_CYC = 50_000_000,
    parameter int CAP         = 15,
    parameter int CNT_W       = 4
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             req_in_i,
    input  logic             req_out_i,
    input  logic             sensor_i,
    output logic             grant_in_o,
    output logic             grant_out_o,
    output logic             ledg_o,
    output logic             ledr_o,
    output logic [6:0]       hex0_o,
    output logic [CNT_W-1:0] occupancy_o,
    output logic             full_o,
    output logic             abort_o
);

    localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    localparam logic DIR_IN  = 1'b1;
    localparam logic DIR_OUT = 1'b0;

    localparam logic [6:0] HEX_ENTRY = 7'b0110000;
    localparam logic [6:0] HEX_EXIT  = 7'b0000001;
    localparam logic [6:0] HEX_IDLE  = 7'b1111111;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GNT_IN   = 2'd1,
        GNT_OUT  = 2'd2,
        WAIT_CLR = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [CNT_W-1:0]   occ_q, occ_d;
    logic               last_dir_q, last_dir_d;

    logic [1:0]         reqInSync_q;
    logic [1:0]         reqOutSync_q;
    logic [2:0]         sensSync_q;

    logic               reqInS;
    logic               reqOutS;
    logic               sensRise;
    logic               isFull;
    logic               inOk;
    logic               outOk;
    logic               abortD;

    assign reqInS   = reqInSync_q[1];
    assign reqOutS  = reqOutSync_q[1];
    assign sensRise = sensSync_q[1] & ~sensSync_q[2];
    assign isFull   = (occ_q == CNT_W'(CAP));
    assign inOk     = reqInS & ~isFull;
    assign outOk    = reqOutS & (occ_q != '0);

    // Bring the switch and sensor inputs into the clock domain; the third sensor flop gives edge detection.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            reqInSync_q  <= '0;
            reqOutSync_q <= '0;
            sensSync_q   <= '0;
        end else begin
            reqInSync_q  <= {reqInSync_q[0], req_in_i};
            reqOutSync_q <= {reqOutSync_q[0], req_out_i};
            sensSync_q   <= {sensSync_q[1:0], sensor_i};
        end
    end

    // State, grant timer, occupancy and last-served direction registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            occ_q      <= '0;
            last_dir_q <= DIR_OUT;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            occ_q      <= occ_d;
            last_dir_q <= last_dir_d;
        end
    end

    // Arbitration, passage counting and timeout; a passage in the timeout cycle is counted, not aborted.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        occ_d      = occ_q;
        last_dir_d = last_dir_q;
        abortD     = 1'b0;
        case (state_q)
            IDLE: begin
                if (inOk && outOk) begin
                    state_d = (last_dir_q == DIR_IN) ? GNT_OUT : GNT_IN;
                    timer_d = '0;
                end else if (inOk) begin
                    state_d = GNT_IN;
                    timer_d = '0;
                end else if (outOk) begin
                    state_d = GNT_OUT;
                    timer_d = '0;
                end
            end
            GNT_IN: begin
                timer_d = timer_q + 1'b1;
                if (sensRise) begin
                    if (!isFull) begin
                        occ_d = occ_q + 1'b1;
                    end
                    last_dir_d = DIR_IN;
                    state_d    = WAIT_CLR;
                end else if (timer_q == TMR_W'(TIMEOUT_CYC - 1)) begin
                    last_dir_d = DIR_IN;
                    abortD     = 1'b1;
                    state_d    = WAIT_CLR;
                end
            end
            GNT_OUT: begin
                timer_d = timer_q + 1'b1;
                if (sensRise) begin
                    if (occ_q != '0) begin
                        occ_d = occ_q - 1'b1;
                    end
                    last_dir_d = DIR_OUT;
                    state_d    = WAIT_CLR;
                end else if (timer_q == TMR_W'(TIMEOUT_CYC - 1)) begin
                    last_dir_d = DIR_OUT;
                    abortD     = 1'b1;
                    state_d    = WAIT_CLR;
                end
            end
            WAIT_CLR: begin
                if (!((last_dir_q == DIR_IN) ? reqInS : reqOutS)) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Lamps, display and grants decoded from the state register alone.
    always_comb begin
        grant_in_o  = 1'b0;
        grant_out_o = 1'b0;
        hex0_o      = HEX_IDLE;
        case (state_q)
            GNT_IN: begin
                grant_in_o = 1'b1;
                hex0_o     = HEX_ENTRY;
            end
            GNT_OUT: begin
                grant_out_o = 1'b1;
                hex0_o      = HEX_EXIT;
            end
            default: begin
                hex0_o = HEX_IDLE;
            end
        endcase
        ledg_o = grant_in_o | grant_out_o;
        ledr_o = ~ledg_o;
    end

    assign occupancy_o = occ_q;
    assign full_o      = isFull;
    assign abort_o     = abortD;

endmodule

// File: tb/tb_turnstile_arbiter.sv
// tb_turnstile_arbiter: directed scenarios for the turnstile arbiter with a short
// timeout and small capacity so grants, aborts and the full condition are quick to reach.
module tb_turnstile_arbiter;

    logic       clk;
    logic       rstN;
    logic       reqIn;
    logic       reqOut;
    logic       sensor;
    logic       grantIn;
    logic       grantOut;
    logic       ledG;
    logic       ledR;
    logic [6:0] hex0;
    logic [1:0] occupancy;
    logic       full;
    logic       abortP;

    int compareCount = 0;
    int failCount    = 0;

    turnstile_arbiter #(
        .TIMEOUT_CYC (8),
        .CAP         (3),
        .CNT_W       (2)
    ) dut (
        .clk_i       (clk),
        .rst_n_i     (rstN),
        .req_in_i    (reqIn),
        .req_out_i   (reqOut),
        .sensor_i    (sensor),
        .grant_in_o  (grantIn),
        .grant_out_o (grantOut),
        .ledg_o      (ledG),
        .ledr_o      (ledR),
        .hex0_o      (hex0),
        .occupancy_o (occupancy),
        .full_o      (full),
        .abort_o     (abortP)
    );

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance n rising edges and settle 1 ns past the last one.
    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic inReq, input logic outReq, input logic sens);
        reqIn  = inReq;
        reqOut = outReq;
        sensor = sens;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        compareCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    // One complete entry: request, passage, release and return to idle.
    task automatic doEntry();
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitCycles(3);
        applyStimulus(1'b1, 1'b0, 1'b1);
        waitCycles(3);
        applyStimulus(1'b0, 1'b0, 1'b0);
        waitCycles(4);
    endtask

    // Directed scenario sequence.
    initial begin
        rstN = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0);
        #12;
        checkOutput("rst_grant_in", {7'd0, grantIn}, 8'd0);
        checkOutput("rst_grant_out", {7'd0, grantOut}, 8'd0);
        checkOutput("rst_ledg", {7'd0, ledG}, 8'd0);
        checkOutput("rst_ledr", {7'd0, ledR}, 8'd1);
        checkOutput("rst_hex0", {1'b0, hex0}, 8'b0111_1111);
        checkOutput("rst_occ", {6'd0, occupancy}, 8'd0);
        checkOutput("rst_full", {7'd0, full}, 8'd0);
        checkOutput("rst_abort", {7'd0, abortP}, 8'd0);
        rstN = 1'b1;
        waitCycles(1);

        $display("[TB] exit refused while empty");
        applyStimulus(1'b0, 1'b1, 1'b0);
        waitCycles(20);
        checkOutput("empty_grant_out", {7'd0, grantOut}, 8'd0);
        checkOutput("empty_ledr", {7'd0, ledR}, 8'd1);
        checkOutput("empty_hex0", {1'b0, hex0}, 8'b0111_1111);
        applyStimulus(1'b0, 1'b0, 1'b0);
        waitCycles(3);

        $display("[TB] basic entry and held-switch behaviour");
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitCycles(2);
        checkOutput("lat_grant_in_early", {7'd0, grantIn}, 8'd0);
        waitCycles(1);
        checkOutput("lat_grant_in", {7'd0, grantIn}, 8'd1);
        checkOutput("entry_hex0", {1'b0, hex0}, 8'b0011_0000);
        checkOutput("entry_ledg", {7'd0, ledG}, 8'd1);
        checkOutput("entry_ledr", {7'd0, ledR}, 8'd0);
        applyStimulus(1'b1, 1'b0, 1'b1);
        waitCycles(2);
        checkOutput("sens_grant_early", {7'd0, grantIn}, 8'd1);
        waitCycles(1);
        checkOutput("sens_grant_in", {7'd0, grantIn}, 8'd0);
        checkOutput("sens_occ1", {6'd0, occupancy}, 8'd1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitCycles(10);
        checkOutput("held_no_regrant", {7'd0, grantIn}, 8'd0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        waitCycles(4);
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitCycles(3);
        checkOutput("regrant_in", {7'd0, grantIn}, 8'd1);
        applyStimulus(1'b1, 1'b0, 1'b1);
        waitCycles(3);
        checkOutput("second_occ2", {6'd0, occupancy}, 8'd2);
        applyStimulus(1'b0, 1'b0, 1'b0);
        waitCycles(4);

        $display("[TB] full room");
        doEntry();
        checkOutput("full_occ3", {6'd0, occupancy}, 8'd3);
        checkOutput("full_flag", {7'd0, full}, 8'd1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitCycles(6);
        checkOutput("full_refuse_in", {7'd0, grantIn}, 8'd0);
        checkOutput("full_refuse_hex", {1'b0, hex0}, 8'b0111_1111);
        applyStimulus(1'b0, 1'b0, 1'b0);
        waitCycles(3);
        applyStimulus(1'b0, 1'b1, 1'b0);
        waitCycles(3);
        checkOutput("exit_grant_out", {7'd0, grantOut}, 8'd1);
        checkOutput("exit_hex0", {1'b0, hex0}, 8'b0000_0001);
        applyStimulus(1'b0, 1'b1, 1'b1);
        waitCycles(3);
        checkOutput("exit_occ2", {6'd0, occupancy}, 8'd2);
        checkOutput("exit_full_clr", {7'd0, full}, 8'd0);
        checkOutput("exit_grant_clr", {7'd0, grantOut}, 8'd0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        waitCycles(4);

        $display("[TB] exit then aborted entry");
        applyStimulus(1'b0, 1'b1, 1'b0);
        waitCycles(3);
        applyStimulus(1'b0, 1'b1, 1'b1);
        waitCycles(3);
        checkOutput("pre_abort_occ1", {6'd0, occupancy}, 8'd1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        waitCycles(4);
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitCycles(3);
        checkOutput("abort_grant_start", {7'd0, grantIn}, 8'd1);
        waitCycles(6);
        checkOutput("abort_grant_c7", {7'd0, grantIn}, 8'd1);
        checkOutput("abort_quiet_c7", {7'd0, abortP}, 8'd0);
        waitCycles(1);
        checkOutput("abort_grant_c8", {7'd0, grantIn}, 8'd1);
        checkOutput("abort_pulse", {7'd0, abortP}, 8'd1);
        waitCycles(1);
        checkOutput("abort_grant_end", {7'd0, grantIn}, 8'd0);
        checkOutput("abort_pulse_end", {7'd0, abortP}, 8'd0);
        checkOutput("abort_occ_same", {6'd0, occupancy}, 8'd1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        waitCycles(4);

        $display("[TB] simultaneous requests after an entry");
        applyStimulus(1'b1, 1'b1, 1'b0);
        waitCycles(3);
        checkOutput("both_grant_out", {7'd0, grantOut}, 8'd1);
        checkOutput("both_no_grant_in", {7'd0, grantIn}, 8'd0);
        applyStimulus(1'b1, 1'b1, 1'b1);
        waitCycles(3);
        checkOutput("both_occ0", {6'd0, occupancy}, 8'd0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitCycles(4);
        checkOutput("both_then_in", {7'd0, grantIn}, 8'd1);

        $display("[TB] passage on the timeout cycle");
        waitCycles(5);
        applyStimulus(1'b1, 1'b0, 1'b1);
        waitCycles(1);
        checkOutput("edge_grant_c7", {7'd0, grantIn}, 8'd1);
        waitCycles(1);
        checkOutput("edge_grant_c8", {7'd0, grantIn}, 8'd1);
        checkOutput("edge_no_abort", {7'd0, abortP}, 8'd0);
        waitCycles(1);
        checkOutput("edge_grant_end", {7'd0, grantIn}, 8'd0);
        checkOutput("edge_occ1", {6'd0, occupancy}, 8'd1);
        checkOutput("edge_abort_end", {7'd0, abortP}, 8'd0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        waitCycles(4);

        $display("[TB] reset during a grant");
        doEntry();
        checkOutput("mid_occ2", {6'd0, occupancy}, 8'd2);
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitCycles(3);
        checkOutput("mid_grant_in", {7'd0, grantIn}, 8'd1);
        rstN = 1'b0;
        #1;
        checkOutput("mid_rst_grant", {7'd0, grantIn}, 8'd0);
        checkOutput("mid_rst_occ", {6'd0, occupancy}, 8'd0);
        checkOutput("mid_rst_hex0", {1'b0, hex0}, 8'b0111_1111);
        checkOutput("mid_rst_ledr", {7'd0, ledR}, 8'd1);
        waitCycles(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
